// File: rtl/sound_dac_pkg.sv
// sound_dac_pkg: shared FSM state type and frame layout constants for the serial sound DAC controller
package sound_dac_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  localparam int FRAME_BITS = 16;
  localparam int PD_MSB = 15;
  localparam int PD_LSB = 14;
  localparam int SMP_MSB = 13;
  localparam int SMP_LSB = 6;
  localparam logic [7:0] DROP_MAX = 8'hFF;
endpackage

// File: rtl/sound_dac_fifo.sv
// sound_dac_fifo: DEPTH-entry sample FIFO (power-of-two DEPTH, pointers wrap naturally)
// Ports: clk, rst (async, active-high), push/din write side, pop/dout read side (dout shows head), empty, full.
// Callers must not push when full without a same-cycle pop, nor pop when empty.
module sound_dac_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] cnt;
  assign dout = mem[rptr];
  assign empty = cnt == '0;
  assign full = cnt == (AW+1)'(DEPTH);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr + 1'b1;
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr] <= din;
endmodule

// File: rtl/sound_dac_ctrl.sv
// sound_dac_ctrl: buffers 8-bit DAC samples and shifts each out as a 16-bit serial DAC frame
// Ports: clk (serial bit clock), rst (async, active-high); sample_valid/sample_data in;
//        dac_sync_n/dac_sdin serial out; busy, overflow (sticky), drop_count (saturating).
// Build option: SOUND_DAC_CTRL_FIFO_EN selects a FIFO_DEPTH-entry FIFO; otherwise a single
//        latest-wins holding register is used.
module sound_dac_ctrl
  import sound_dac_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 2,
  parameter logic [1:0] PD_BITS = 2'b00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sample_valid,
  input  logic [7:0] sample_data,
  output logic       dac_sync_n,
  output logic       dac_sdin,
  output logic       busy,
  output logic       overflow,
  output logic [7:0] drop_count
);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic [FRAME_BITS-1:0] shreg, frame;
  logic [7:0] dout;
  logic pop, empty, full, drop;
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      GAP_CYCLES < 1 || GAP_CYCLES > 15) begin : g_bad_params
    $error("sound_dac_ctrl: FIFO_DEPTH or GAP_CYCLES out of range");
  end
  assign pop = state == IDLE && !empty;
  assign drop = sample_valid && full && !pop;
`ifdef SOUND_DAC_CTRL_FIFO_EN
  sound_dac_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(sample_valid && !drop),
    .pop(pop),
    .din(sample_data),
    .dout(dout),
    .empty(empty),
    .full(full)
  );
`else
  logic held;
  logic [7:0] hold;
  assign empty = !held;
  assign full = held;
  assign dout = hold;
  // a new sample always lands; it replaces an unpopped one (counted as a drop)
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      held <= 1'b0;
      hold <= '0;
    end else begin
      held <= sample_valid || (held && !pop);
      if (sample_valid) hold <= sample_data;
    end
`endif
  always_comb begin
    frame = '0;
    frame[PD_MSB:PD_LSB] = PD_BITS;
    frame[SMP_MSB:SMP_LSB] = dout;
  end
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + 4'd1;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (pop) state_nx = SHIFT;
      end
      SHIFT: if (cnt == 4'(FRAME_BITS - 1)) begin
        state_nx = GAP;
        cnt_nx = '0;
      end
      GAP: if (cnt == 4'(GAP_CYCLES - 1)) begin
        state_nx = IDLE;
        cnt_nx = '0;
      end
      default: begin
        state_nx = IDLE;
        cnt_nx = '0;
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      shreg <= '0;
      overflow <= 1'b0;
      drop_count <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      if (pop) shreg <= frame;
      else if (state == SHIFT) shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != DROP_MAX) drop_count <= drop_count + 8'd1;
      end
    end
  // outputs decode straight from state so an async reset releases sync_n immediately
  assign dac_sync_n = state != SHIFT;
  assign dac_sdin = state == SHIFT && shreg[FRAME_BITS-1];
  assign busy = state != IDLE || !empty;
endmodule

// File: tb/tb_sound_dac_ctrl.sv
// tb_sound_dac_ctrl: self-checking bench with a timeline model of the DAC controller plus directed literal checks
module tb_sound_dac_ctrl;
  localparam int G = 2;
`ifdef SOUND_DAC_CTRL_FIFO_EN
  localparam int CAP = 4;
`else
  localparam int CAP = 1;
`endif
  logic clk = 0, rst = 1, sample_valid = 0;
  logic [7:0] sample_data = 0;
  logic dac_sync_n, dac_sdin, busy, overflow;
  logic [7:0] drop_count;
  int checks = 0, errors = 0, cyc = 0;
  logic [7:0] q[$];
  int t = -1;
  logic [15:0] fw = 0;
  bit m_ovf = 0;
  int m_drop = 0;
  bit popm, fullm;
  logic [7:0] pv;
  logic [15:0] frames[$];
  int fstart[$];
  logic [15:0] sh = 0;
  int nbits = 0;
  sound_dac_ctrl #(.FIFO_DEPTH(4), .GAP_CYCLES(G), .PD_BITS(2'b00)) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
    .dac_sync_n(dac_sync_n), .dac_sdin(dac_sdin), .busy(busy), .overflow(overflow),
    .drop_count(drop_count)
  );
  always #5 clk = ~clk;
  initial forever @(posedge clk) cyc++;
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask
  // model: t<0 idle, 0..15 sending bit 15-t, 16..16+G-1 gap; buffer is a queue of capacity CAP
  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      q.delete();
      t = -1;
      m_ovf = 0;
      m_drop = 0;
    end else begin
      fullm = q.size() == CAP;
      popm = t < 0 && q.size() > 0;
      if (popm) pv = q.pop_front();
      if (sample_valid) begin
        if (fullm && !popm) begin
          m_ovf = 1;
          if (m_drop < 255) m_drop++;
          if (CAP == 1) q[0] = sample_data;
        end else q.push_back(sample_data);
      end
      if (popm) begin
        t = 0;
        fw = {2'b00, pv, 6'b000000};
      end else if (t >= 0) begin
        t++;
        if (t == 16 + G) t = -1;
      end
    end
  end
  initial forever begin
    @(negedge clk);
    chk("sync_n", dac_sync_n, !(t >= 0 && t < 16));
    chk("sdin", dac_sdin, (t >= 0 && t < 16) ? fw[15-t] : 0);
    chk("busy", busy, t >= 0 || q.size() > 0);
    chk("overflow", overflow, m_ovf);
    chk("drop_count", drop_count, m_drop);
  end
  initial forever begin
    @(negedge clk);
    if (rst) nbits = 0;
    else if (!dac_sync_n) begin
      if (nbits == 0) fstart.push_back(cyc);
      sh = {sh[14:0], dac_sdin};
      nbits++;
      if (nbits == 16) begin
        frames.push_back(sh);
        nbits = 0;
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required to finish");
    $fatal(1);
  end
  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    frames.delete();
    fstart.delete();
    rst = 0;
  endtask
  task automatic pulse_seq(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid = 1;
      sample_data = base + 8'(i);
    end
    @(negedge clk);
    sample_valid = 0;
  endtask
  task automatic wait_idle(output int c);
    c = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      #1;
      if (!busy && dac_sync_n) begin
        c = cyc;
        return;
      end
    end
    chk("wait_idle_timeout", 1, 0);
  endtask
  task automatic wait_frame_start(input int n);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (fstart.size() > n) return;
    end
    chk("frame_start_timeout", 1, 0);
  endtask
  function automatic logic [15:0] fr(input logic [7:0] d);
    return {2'b00, d, 6'b000000};
  endfunction
  int sc, ic, tgt, d0, n0, f0;
  bit hit;
  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_sync_n", dac_sync_n, 1);
    chk("rst_sdin", dac_sdin, 0);
    chk("rst_busy", busy, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    do_reset();
    // single sample A5
    @(negedge clk);
    sc = cyc;
    sample_valid = 1;
    sample_data = 8'hA5;
    @(negedge clk);
    sample_valid = 0;
    wait_idle(ic);
    chk("single_nframes", frames.size(), 1);
    if (frames.size() >= 1) begin
      chk("single_word", frames[0], 16'h2940);
      chk("single_latency", fstart[0] - sc, 2);
      chk("single_busy_fall", ic - fstart[0], 16 + G);
    end
    // burst 01..04
    do_reset();
    pulse_seq(4, 8'h01);
    wait_idle(ic);
`ifdef SOUND_DAC_CTRL_FIFO_EN
    chk("burst_nframes", frames.size(), 4);
    for (int i = 0; i < 4 && i < frames.size(); i++) chk("burst_word", frames[i], fr(8'(i + 1)));
    for (int i = 1; i < 4 && i < fstart.size(); i++) chk("burst_spacing", fstart[i] - fstart[i-1], 19);
    chk("burst_overflow", overflow, 0);
`else
    chk("burst_nframes", frames.size(), 2);
    if (frames.size() == 2) begin
      chk("burst_word0", frames[0], 16'h0040);
      chk("burst_word1", frames[1], 16'h0100);
      chk("burst_spacing", fstart[1] - fstart[0], 19);
    end
    chk("burst_drop", drop_count, 2);
`endif
    // overflow with 6 strobes
    do_reset();
    pulse_seq(6, 8'h01);
    wait_idle(ic);
`ifdef SOUND_DAC_CTRL_FIFO_EN
    chk("ovf_nframes", frames.size(), 5);
    chk("ovf_drop", drop_count, 1);
`else
    chk("ovf_nframes", frames.size(), 2);
    chk("ovf_drop", drop_count, 4);
`endif
    chk("ovf_flag", overflow, 1);
    // strobe landing in the pop cycle while the buffer is full
    do_reset();
    pulse_seq(1, 8'h11);
    repeat (2) @(negedge clk);
    pulse_seq(4, 8'h22);
    wait_frame_start(0);
    tgt = fstart[0] + 18;
    hit = 0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clk);
      if (cyc == tgt) begin
        hit = 1;
        d0 = drop_count;
        sample_valid = 1;
        sample_data = 8'h66;
        @(negedge clk);
        sample_valid = 0;
        #1;
        chk("popcyc_drop_unchanged", drop_count, d0);
      end
    end
    chk("popcyc_reached", hit, 1);
    wait_idle(ic);
`ifdef SOUND_DAC_CTRL_FIFO_EN
    chk("popcyc_nframes", frames.size(), 6);
    chk("popcyc_drop", drop_count, 0);
`else
    chk("popcyc_nframes", frames.size(), 3);
    chk("popcyc_drop", drop_count, 3);
`endif
    if (frames.size() > 0) chk("popcyc_last", frames[frames.size()-1], 16'h1980);
    // reset asserted mid-frame at bit 7
    do_reset();
    pulse_seq(1, 8'hC3);
    wait_frame_start(0);
    repeat (8) @(negedge clk);
    #1;
    chk("midrst_bit7_before", dac_sdin, 1);
    #1;
    rst = 1;
    #1;
    chk("midrst_sync_n", dac_sync_n, 1);
    chk("midrst_sdin", dac_sdin, 0);
    chk("midrst_busy", busy, 0);
    n0 = fstart.size();
    f0 = frames.size();
    repeat (2) @(negedge clk);
    rst = 0;
    repeat (40) @(negedge clk);
    chk("midrst_no_restart", fstart.size(), n0);
    chk("midrst_no_frame", frames.size(), f0);
    chk("midrst_drop", drop_count, 0);
    chk("midrst_overflow", overflow, 0);
    // three strobes during one frame
    do_reset();
    pulse_seq(1, 8'h77);
    wait_frame_start(0);
    pulse_seq(1, 8'h10);
    repeat (2) @(negedge clk);
    pulse_seq(1, 8'h20);
    repeat (2) @(negedge clk);
    pulse_seq(1, 8'h30);
    wait_idle(ic);
`ifdef SOUND_DAC_CTRL_FIFO_EN
    chk("latest_nframes", frames.size(), 4);
    chk("latest_drop", drop_count, 0);
`else
    chk("latest_nframes", frames.size(), 2);
    chk("latest_drop", drop_count, 2);
`endif
    if (frames.size() > 0) chk("latest_word", frames[frames.size()-1], 16'h0C00);
    // drop counter saturation
    do_reset();
    for (int i = 0; i < 320; i++) begin
      @(negedge clk);
      sample_valid = 1;
      sample_data = 8'(i);
    end
    @(negedge clk);
    sample_valid = 0;
    wait_idle(ic);
    chk("sat_drop", drop_count, 255);
    chk("sat_overflow", overflow, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
